// File: rtl/touch_adc_if.sv
// touch_adc_if: SPI master for an ADS7843-class touch ADC (pen debounce, X/Y 8-bit conversions).
// Define TOUCH_AVG_EN to publish the average of every 4 conversion pairs instead of each pair.
// state    | meaning
// IDLE     | waiting for synced pen-down
// DEBOUNCE | counting consecutive low penirq samples
// XFER_X   | 24-dclk frame, X command and data
// XFER_Y   | 24-dclk frame, Y command and data
// PUBLISH  | one cycle, x/y updated, new_coord_r high
// GAP      | idle interval before next pair or release
module touch_adc_if #(
    parameter int         CLK_DIV      = 16,
    parameter int         DEBOUNCE_CYC = 64,
    parameter int         SAMPLE_GAP   = 2048,
    parameter logic [7:0] X_CMD        = 8'hD8,
    parameter logic [7:0] Y_CMD        = 8'h98
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       adc_penirq_n,
    input  logic       adc_dout,
    output logic       adc_dclk,
    output logic       adc_cs_n,
    output logic       adc_din,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       new_coord_r,
    output logic       transmit_en,
    output logic       penirq_n
);
    localparam int DW   = $clog2(CLK_DIV + 1);
    localparam int TMAX = (DEBOUNCE_CYC > SAMPLE_GAP) ? DEBOUNCE_CYC : SAMPLE_GAP;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, DEBOUNCE, XFER_X, XFER_Y, PUBLISH, GAP} state_t;
    state_t state, state_n;

    logic [1:0]    sync_q;
    logic [DW-1:0] div_cnt;
    logic [TW-1:0] tmr;
    logic [4:0]    bit_idx;
    logic [4:0]    nxt_idx;
    logic [7:0]    shreg;
    logic [7:0]    x_cap;
    logic [7:0]    cmd_sel;
    logic [7:0]    start_cmd;
    logic [7:0]    pub_x;
    logic [7:0]    pub_y;
    logic          nxt_din;
    logic          tick;
    logic          frame_end;
    logic          last_pair;
    logic          xfer_n;

    assign penirq_n  = sync_q[1];
    assign tick      = (div_cnt == '0);
    assign frame_end = tick && adc_dclk && (bit_idx == 5'd23);
    assign nxt_idx   = bit_idx + 5'd1;
    assign cmd_sel   = (state == XFER_X) ? X_CMD : Y_CMD;
    assign start_cmd = (state_n == XFER_X) ? X_CMD : Y_CMD;
    assign nxt_din   = (nxt_idx < 5'd8) ? cmd_sel[3'd7 - nxt_idx[2:0]] : 1'b0;
    assign xfer_n    = (state_n == XFER_X) || (state_n == XFER_Y);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_n;
    end

    // penirq_n is not consulted from XFER_X through PUBLISH: the ADC drives it invalid then
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (!penirq_n) state_n = DEBOUNCE;
            DEBOUNCE: begin
                if (penirq_n)         state_n = IDLE;
                else if (tmr == '0)   state_n = XFER_X;
            end
            XFER_X:   if (frame_end) state_n = XFER_Y;
            XFER_Y:   if (frame_end) state_n = last_pair ? PUBLISH : GAP;
            PUBLISH:  state_n = GAP;
            GAP:      if (tmr == '0) state_n = penirq_n ? IDLE : XFER_X;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q      <= 2'b11;
            div_cnt     <= '0;
            tmr         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            x_cap       <= '0;
            adc_dclk    <= 1'b0;
            adc_cs_n    <= 1'b1;
            adc_din     <= 1'b0;
            x           <= '0;
            y           <= '0;
            new_coord_r <= 1'b0;
            transmit_en <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], adc_penirq_n};
            adc_cs_n    <= !xfer_n;
            transmit_en <= (state_n != IDLE) && (state_n != DEBOUNCE);
            new_coord_r <= (state_n == PUBLISH);

            // the IDLE sample that leaves IDLE counts as the first debounce sample
            if (state == IDLE && !penirq_n)
                tmr <= TW'(DEBOUNCE_CYC - 2);
            else if (state_n == GAP && state != GAP)
                tmr <= TW'(SAMPLE_GAP - 1);
            else if (tmr != '0)
                tmr <= tmr - 1'b1;

            if (xfer_n) begin
                if (state_n != state) begin
                    div_cnt  <= DW'(CLK_DIV - 1);
                    adc_dclk <= 1'b0;
                    bit_idx  <= '0;
                    adc_din  <= start_cmd[7];
                end else if (tick) begin
                    div_cnt <= DW'(CLK_DIV - 1);
                    if (!adc_dclk) begin
                        adc_dclk <= 1'b1;
                        if (bit_idx >= 5'd9 && bit_idx <= 5'd16)
                            shreg <= {shreg[6:0], adc_dout};
                    end else begin
                        adc_dclk <= 1'b0;
                        bit_idx  <= nxt_idx;
                        adc_din  <= nxt_din;
                    end
                end else begin
                    div_cnt <= div_cnt - 1'b1;
                end
            end else begin
                div_cnt  <= '0;
                adc_dclk <= 1'b0;
                adc_din  <= 1'b0;
                bit_idx  <= '0;
            end

            if (state == XFER_X && frame_end) x_cap <= shreg;

            if (state_n == PUBLISH) begin
                x <= pub_x;
                y <= pub_y;
            end
        end
    end

`ifdef TOUCH_AVG_EN
    logic [9:0] sum_x, sum_y, sum_x_n, sum_y_n;
    logic [1:0] pair_cnt;

    assign sum_x_n   = sum_x + {2'b00, x_cap};
    assign sum_y_n   = sum_y + {2'b00, shreg};
    assign last_pair = (pair_cnt == 2'd3);
    assign pub_x     = sum_x_n[9:2];
    assign pub_y     = sum_y_n[9:2];

    always_ff @(posedge sys_clk) begin
        if (sys_rst || state_n == IDLE) begin
            sum_x    <= '0;
            sum_y    <= '0;
            pair_cnt <= '0;
        end else if (state == XFER_Y && frame_end) begin
            if (last_pair) begin
                sum_x    <= '0;
                sum_y    <= '0;
                pair_cnt <= '0;
            end else begin
                sum_x    <= sum_x_n;
                sum_y    <= sum_y_n;
                pair_cnt <= pair_cnt + 2'd1;
            end
        end
    end
`else
    assign last_pair = 1'b1;
    assign pub_x     = x_cap;
    assign pub_y     = shreg;
`endif

endmodule

// File: tb/tb_touch_adc_if.sv
// Bench for touch_adc_if: behavioural ADS7843 model plus x/y scoreboard popped on new_coord_r.
// Build with TOUCH_AVG_EN defined to exercise the 4-pair averaging variant.
module tb_touch_adc_if;
    localparam int SAMPLE_GAP = 2048;
    localparam int FRAME_CYC  = 24 * 2 * 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       adc_penirq_n = 1'b1;
    logic       adc_dout = 1'b0;
    logic       adc_dclk, adc_cs_n, adc_din;
    logic [7:0] x, y;
    logic       new_coord_r, transmit_en, penirq_n;

    touch_adc_if dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .adc_penirq_n (adc_penirq_n),
        .adc_dout     (adc_dout),
        .adc_dclk     (adc_dclk),
        .adc_cs_n     (adc_cs_n),
        .adc_din      (adc_din),
        .x            (x),
        .y            (y),
        .new_coord_r  (new_coord_r),
        .transmit_en  (transmit_en),
        .penirq_n     (penirq_n)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // ADC model: conversion data per pair index, command bits captured on dclk rise
    logic [7:0] xs [4];
    logic [7:0] ys [4];
    int         k = 0;
    int         rises = 0;
    int         pair_no = 0;
    int         pair_base = 0;
    bit         frame_y = 0;
    logic [7:0] cmd_rx = '0;

    always @(posedge adc_dclk or posedge adc_cs_n) begin
        if (adc_cs_n) begin
            k       = 0;
            frame_y = 0;
        end else begin
            rises++;
            k++;
            if (k <= 8) cmd_rx = {cmd_rx[6:0], adc_din};
            if (k == 24) begin
                if (frame_y) begin
                    chk("cmd_y", cmd_rx, 8'h98);
                    pair_no++;
                end else begin
                    chk("cmd_x", cmd_rx, 8'hD8);
                end
                frame_y = !frame_y;
                k = 0;
            end
        end
    end

    always @(negedge adc_dclk) begin
        logic [7:0] d;
        int         idx;
        idx = (pair_no - pair_base) & 3;
        d   = (cmd_rx[6:4] == 3'b101) ? xs[idx] : ys[idx];
        if (!adc_cs_n && k >= 9 && k <= 16) adc_dout = d[3'(16 - k)];
        else                                adc_dout = 1'b0;
    end

    int cs_fall = 0;
    always @(negedge adc_cs_n) cs_fall++;

    logic [15:0] exp_q [$];
    int          pulse_cnt = 0;

    always @(negedge sys_clk) begin
        if (new_coord_r === 1'b1) begin
            pulse_cnt++;
            chk("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("sb_xy", {x, y}, exp_q.pop_front());
        end
    end

    initial begin
        int n;
        int lo;
        int cs0;
        int p0;
        int r0;

        for (int i = 0; i < 4; i++) begin
            xs[i] = 8'h00;
            ys[i] = 8'h00;
        end

        // reset
        step(4);
        chk("rst_ctl", {adc_dclk, adc_cs_n, adc_din, new_coord_r, transmit_en, penirq_n}, 6'b010001);
        chk("rst_xy", {x, y}, 16'h0000);
        chk("rst_no_dclk", rises, 0);
        sys_rst = 1'b0;
        step(3);

        // short glitch below the debounce threshold
        cs0 = cs_fall;
        adc_penirq_n = 1'b0;
        step(1);
        chk("sync_lat1", penirq_n, 1'b1);
        step(1);
        chk("sync_lat2", penirq_n, 1'b0);
        step(8);
        adc_penirq_n = 1'b1;
        step(150);
        chk("glitch_cs", cs_fall - cs0, 0);
        chk("glitch_ten", {transmit_en, adc_cs_n}, 2'b01);

`ifndef TOUCH_AVG_EN
        // single pen-down of 100 cycles
        for (int i = 0; i < 4; i++) begin
            xs[i] = 8'h5A;
            ys[i] = 8'hC3;
        end
        pair_base = pair_no;
        exp_q.push_back(16'h5AC3);
        r0 = rises;
        p0 = pulse_cnt;
        adc_penirq_n = 1'b0;
        n = 0;
        while (adc_cs_n !== 1'b0 && n < 300) begin
            step(1);
            n++;
        end
        chk("debounce_lat", n, 66);
        chk("ten_at_cs", transmit_en, 1'b1);
        lo = 0;
        while (adc_cs_n === 1'b0 && lo < 2000) begin
            if (n + lo == 100) adc_penirq_n = 1'b1;
            step(1);
            lo++;
        end
        chk("cs_low_len", lo, 2 * FRAME_CYC);
        chk("pub_pulse", new_coord_r, 1'b1);
        chk("pub_xy", {x, y}, 16'h5AC3);
        chk("dclk_periods", rises - r0, 48);
        n = 0;
        while (transmit_en === 1'b1 && n < 3000) begin
            step(1);
            chk("ten_no_pulse", new_coord_r, 1'b0);
            n++;
        end
        chk("gap_len", n, SAMPLE_GAP + 1);
        chk("one_pulse", pulse_cnt - p0, 1);
        chk("hold_xy", {x, y}, 16'h5AC3);

        // release during XFER_Y
        for (int i = 0; i < 4; i++) begin
            xs[i] = 8'h33;
            ys[i] = 8'h77;
        end
        pair_base = pair_no;
        exp_q.push_back(16'h3377);
        adc_penirq_n = 1'b0;
        n = 0;
        while (adc_cs_n !== 1'b0 && n < 300) begin
            step(1);
            n++;
        end
        chk("t4_cs_low", adc_cs_n, 1'b0);
        step(FRAME_CYC + 50);
        chk("t4_in_y", {adc_cs_n, frame_y}, 2'b01);
        adc_penirq_n = 1'b1;
        n = 0;
        while (adc_cs_n === 1'b0 && n < 2000) begin
            step(1);
            n++;
        end
        chk("t4_pub", {new_coord_r, x, y}, 17'h13377);
        n = 0;
        while (transmit_en === 1'b1 && n < 3000) begin
            step(1);
            n++;
        end
        chk("t4_gap_len", n, SAMPLE_GAP + 1);
        cs0 = cs_fall;
        step(3000);
        chk("t4_quiet", cs_fall - cs0, 0);
        chk("t4_hold", {transmit_en, x, y}, 17'h03377);
`endif

        // reset in the middle of the X frame
        for (int i = 0; i < 4; i++) begin
            xs[i] = 8'h11;
            ys[i] = 8'h22;
        end
        p0 = pulse_cnt;
        adc_penirq_n = 1'b0;
        n = 0;
        while (!(adc_cs_n === 1'b0 && k == 12) && n < 1500) begin
            step(1);
            n++;
        end
        chk("t5_bit12", {adc_cs_n, frame_y, k[4:0]}, {1'b0, 1'b0, 5'd12});
        sys_rst = 1'b1;
        step(1);
        chk("t5_abort", {adc_cs_n, adc_dclk, transmit_en, new_coord_r}, 4'b1000);
        chk("t5_xy", {x, y}, 16'h0000);
        adc_penirq_n = 1'b1;
        step(3);
        sys_rst = 1'b0;
        cs0 = cs_fall;
        step(200);
        chk("t5_idle", {cs_fall - cs0, pulse_cnt - p0}, 64'd0);

`ifdef TOUCH_AVG_EN
        // 4-pair averaging
        xs[0] = 8'h10; xs[1] = 8'h12; xs[2] = 8'h14; xs[3] = 8'h16;
        for (int i = 0; i < 4; i++) ys[i] = 8'h40;
        pair_base = pair_no;
        p0 = pulse_cnt;
        exp_q.push_back(16'h1340);
        adc_penirq_n = 1'b0;
        n = 0;
        while (pulse_cnt == p0 && n < 20000) begin
            step(1);
            n++;
        end
        chk("avg_pulse", pulse_cnt - p0, 1);
        chk("avg_pairs", pair_no - pair_base, 4);
        chk("avg_xy", {x, y}, 16'h1340);
        adc_penirq_n = 1'b1;
        n = 0;
        while (transmit_en === 1'b1 && n < 3000) begin
            step(1);
            n++;
        end
        chk("avg_rel", transmit_en, 1'b0);

        // release after two pairs discards the partial group
        pair_base = pair_no;
        p0 = pulse_cnt;
        adc_penirq_n = 1'b0;
        n = 0;
        while (pair_no - pair_base < 2 && n < 10000) begin
            step(1);
            n++;
        end
        chk("avg2_pairs", pair_no - pair_base, 2);
        adc_penirq_n = 1'b1;
        n = 0;
        while (transmit_en === 1'b1 && n < 3000) begin
            step(1);
            n++;
        end
        step(10);
        chk("avg2_no_pulse", pulse_cnt - p0, 0);
        chk("avg2_hold", {transmit_en, x, y}, 17'h01340);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
